iu_fetch_q: RTL



---
 rtl/iu_pkg.sv | 14 +
 rtl/iu_fetch_ram.sv | 48 ++++
 rtl/iu_fetch_q.sv | 119 +++++++++++
 3 files changed

// File: rtl/iu_pkg.sv
// Shared constants and the prefetch-queue entry type for the integer-unit fetch front end.
// Queue entries carry pc4 at IU_AW_MAX bits, so AW may be at most 64; unused high bits are tied to zero.
package iu_pkg;

  localparam logic [31:0] IU_NOP     = 32'h0000_0000;
  localparam int          IU_PC_STEP = 4;
  localparam int          IU_AW_MAX  = 64;

  typedef struct packed {
    logic [31:0]          inst;
    logic [IU_AW_MAX-1:0] pc4;
  } iu_qent_t;

endpackage

// File: rtl/iu_fetch_ram.sv
// DEPTH-entry prefetch FIFO storage: the head is read combinationally; push and pop take effect on the clock edge.
// No full/empty protection: the caller's credit rule guarantees no push into a full FIFO and no pop from an empty one.
module iu_fetch_ram
  import iu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   push_vld,
  input  iu_qent_t               push_dat,
  input  logic                   pop_vld,
  output iu_qent_t               head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iu_qent_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_vld) - CW'(pop_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/iu_fetch_q.sv
// Credit-based instruction prefetch queue: fetch-to-decode latency 2 cycles (1 with `IFQ_BYPASS_EN); decode backpressure via dec_ready.
// Requests stop when queued + outstanding + dropped fetches reach DEPTH; redirect flushes the queue and turns owed responses into drops.
module iu_fetch_q
  import iu_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [AW-1:0] inst_pc4,
  input  logic          dec_ready
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] STEP = AW'(IU_PC_STEP);

  logic [AW-1:0] fetch_pc, resp_pc, resp_pc4, redir_pc;
  logic [CW-1:0] count, outstanding, drop, outstanding_n, drop_n;
  logic [CW+1:0] used;
  logic          accept, rv_keep, rv_drop, byp_vld, push_vld, pop_vld, head_pop;
  iu_qent_t      head_dat, push_dat;
  logic          unused_bits;

  assign redir_pc    = {redirect_pc[AW-1:2], 2'b00};
  assign resp_pc4    = resp_pc + STEP;
  assign unused_bits = ^{redirect_pc[1:0], head_dat.pc4};

  // Every entry slot is reserved from request until its response is consumed or dropped.
  assign used      = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop);
  assign imem_req  = !clr && !redirect && (used < (CW+2)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ack;

  assign rv_drop = imem_rvalid && (drop != '0);
  assign rv_keep = imem_rvalid && (drop == '0);

`ifdef IFQ_BYPASS_EN
  assign byp_vld = rv_keep && !redirect && (count == '0);
`else
  assign byp_vld = 1'b0;
`endif

  assign inst_valid = (count != '0) || byp_vld;

  always_comb begin
    inst     = IU_NOP;
    inst_pc4 = resp_pc4;
    if (count != '0) begin
      inst     = head_dat.inst;
      inst_pc4 = head_dat.pc4[AW-1:0];
    end else if (byp_vld) begin
      inst     = imem_rdata;
      inst_pc4 = resp_pc4;
    end
  end

  assign pop_vld  = inst_valid && dec_ready && !redirect;
  assign head_pop = pop_vld && (count != '0);
  // A bypassed instruction taken by decode the same cycle never occupies a slot.
  assign push_vld = rv_keep && !redirect && !(byp_vld && dec_ready);
  assign push_dat = {imem_rdata, IU_AW_MAX'(resp_pc4)};

  always_comb begin
    outstanding_n = outstanding;
    drop_n        = drop;
    if (redirect) begin
      drop_n        = drop + outstanding - CW'(imem_rvalid);
      outstanding_n = '0;
    end else begin
      outstanding_n = outstanding + CW'(accept) - CW'(rv_keep);
      drop_n        = drop - CW'(rv_drop);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_n;
      drop        <= drop_n;
      if (redirect) begin
        fetch_pc <= redir_pc;
        resp_pc  <= redir_pc;
      end else begin
        if (accept)  fetch_pc <= fetch_pc + STEP;
        if (rv_keep) resp_pc  <= resp_pc4;
      end
    end
  end

  iu_fetch_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .clr      (clr),
    .flush    (redirect),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (head_pop),
    .head_dat (head_dat),
    .count    (count)
  );

  a_rvalid_owed : assert property (@(posedge clk) disable iff (clr)
    imem_rvalid |-> (outstanding != '0 || drop != '0));

endmodule
